switch_port_cfg: RTL and testbench

Configuration-register stage of the switch: it consumes the memory-port write/read transactions driven on the switch memory interface and holds one destination-address register per output port. It also provides a registered address-lookup path that the packet router queries to map a packet's destination byte to a one-hot output-port select. It sits directly downstream of the memory interface and upstream of the router/output queues.

---
 rtl/switch_cfg_pkg.sv | 35 +++
 rtl/switch_port_cfg_if.sv | 35 +++
 rtl/switch_port_match.sv | 27 ++
 rtl/switch_port_cfg.sv | 98 +++++++++
 tb/tb_switch_port_cfg.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/switch_cfg_pkg.sv
// -----------------------------------------------------------------------------
// switch_cfg_pkg
// Shared constants, types and helpers for the switch port-configuration stage.
//   NUM_PORTS     : number of output ports (equals 2**ADDR_W)
//   ADDR_W        : width of the register index on the memory bus
//   DATA_W        : width of write data and of a port address
//   port_addr_t   : one port's destination address
//   port_sel_t    : one bit per output port
//   port_idx_t    : register index on the memory bus
//   onehot_lowest : keep only the lowest set bit of a match vector
// -----------------------------------------------------------------------------
package switch_cfg_pkg;

  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 4;

  typedef logic [DATA_W-1:0]    port_addr_t;
  typedef logic [NUM_PORTS-1:0] port_sel_t;
  typedef logic [ADDR_W-1:0]    port_idx_t;

  // Priority encoder: the lowest matching port wins when several match.
  function automatic port_sel_t onehot_lowest(input port_sel_t v);
    port_sel_t r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_port_cfg_if.sv
// -----------------------------------------------------------------------------
// switch_port_cfg_if
// Memory-port transactions, lookup request/response and read-back data of the
// port-configuration stage.
//   master : drives mem_* and lk_valid/lk_da (memory interface / router side)
//   slave  : the configuration stage; drives lookup results and read data
// -----------------------------------------------------------------------------
interface switch_port_cfg_if;
  import switch_cfg_pkg::*;

  logic       mem_en;
  logic       mem_rd_wr;     // 1 = write, 0 = read
  port_idx_t  mem_add;
  port_addr_t mem_data;

  logic       lk_valid;
  port_addr_t lk_da;
  logic       lk_out_valid;
  port_sel_t  lk_port;
  logic       lk_miss;

  logic       rd_valid;
  port_addr_t rd_data;

  modport master (
    output mem_en, mem_rd_wr, mem_add, mem_data, lk_valid, lk_da,
    input  lk_out_valid, lk_port, lk_miss, rd_valid, rd_data
  );

  modport slave (
    input  mem_en, mem_rd_wr, mem_add, mem_data, lk_valid, lk_da,
    output lk_out_valid, lk_port, lk_miss, rd_valid, rd_data
  );

endinterface

// File: rtl/switch_port_match.sv
// -----------------------------------------------------------------------------
// switch_port_match
// Combinational compare of a destination address against every configured port.
//   lk_da     : destination address under lookup
//   port_addr : per-port configured addresses
//   cfg_valid : per-port "has been written" flags; unwritten ports never match
//   match     : raw (not priority-encoded) match vector
// -----------------------------------------------------------------------------
module switch_port_match
  import switch_cfg_pkg::*;
(
  input  port_addr_t lk_da,
  input  port_addr_t port_addr [NUM_PORTS],
  input  port_sel_t  cfg_valid,
  output port_sel_t  match
);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match[i] = cfg_valid[i] && (port_addr[i] == lk_da);
    end
  end

endmodule

// File: rtl/switch_port_cfg.sv
// -----------------------------------------------------------------------------
// switch_port_cfg
// Holds one destination address per output port, loaded by memory-port writes,
// and answers registered lookups (destination byte -> one-hot port select).
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : memory transactions, lookup request/response, read-back
//   cfg_valid      : bit i set once port i has been written
//   dup_err        : sticky flag, two configured ports hold the same address
// Optional feature: define SWITCH_CFG_READBACK_EN to return port_addr[mem_add]
// on rd_data/rd_valid one cycle after a read; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module switch_port_cfg
  import switch_cfg_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  switch_port_cfg_if.slave  bus,
  output port_sel_t         cfg_valid,
  output logic              dup_err
);

  port_addr_t port_addr [NUM_PORTS];
  port_sel_t  match;
  logic       dup_now;
  logic       wr_en;

  assign wr_en = bus.mem_en & bus.mem_rd_wr;

  // NOTE: the address registers are reset even though they sit behind
  // cfg_valid, so a read-back of an unwritten port returns a defined 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes a same-edge lookup or read
  // see the old contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) port_addr[i] <= '0;
      cfg_valid <= '0;
    end else if (wr_en) begin
      port_addr[bus.mem_add] <= bus.mem_data;
      cfg_valid[bus.mem_add] <= 1'b1;
    end
  end

  switch_port_match u_match (
    .lk_da     (bus.lk_da),
    .port_addr (port_addr),
    .cfg_valid (cfg_valid),
    .match     (match)
  );

  // Lookup result: one-cycle pulse per request, port select cleared when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.lk_out_valid <= 1'b0;
      bus.lk_port      <= '0;
      bus.lk_miss      <= 1'b0;
    end else begin
      bus.lk_out_valid <= bus.lk_valid;
      bus.lk_port      <= bus.lk_valid ? onehot_lowest(match) : '0;
      bus.lk_miss      <= bus.lk_valid && (match == '0);
    end
  end

  // Pairwise compare of configured ports; only written ports take part.
  always_comb begin
    dup_now = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (cfg_valid[i] && cfg_valid[j] && (port_addr[i] == port_addr[j]))
          dup_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dup_err <= 1'b0;
    else if (dup_now) dup_err <= 1'b1;
  end

`ifdef SWITCH_CFG_READBACK_EN
  logic rd_en;
  assign rd_en = bus.mem_en & ~bus.mem_rd_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= rd_en;
      if (rd_en) bus.rd_data <= port_addr[bus.mem_add];
    end
  end
`else
  assign bus.rd_valid = 1'b0;
  assign bus.rd_data  = '0;
`endif

endmodule

// File: tb/tb_switch_port_cfg.sv
// -----------------------------------------------------------------------------
// tb_switch_port_cfg
// Directed self-checking bench for switch_port_cfg. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point, so every
// value read reflects the registers loaded by the preceding edge.
// -----------------------------------------------------------------------------
module tb_switch_port_cfg;
  import switch_cfg_pkg::*;

  logic      clock;
  logic      reset_n;
  port_sel_t cfg_valid;
  logic      dup_err;

  int n_cmp = 0;
  int n_err = 0;

  switch_port_cfg_if bus ();

  switch_port_cfg dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .cfg_valid (cfg_valid),
    .dup_err   (dup_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  `ifdef SWITCH_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
  `else
  localparam bit READBACK = 1'b0;
  `endif

  task automatic idle_inputs();
    bus.mem_en    = 1'b0;
    bus.mem_rd_wr = 1'b0;
    bus.mem_add   = '0;
    bus.mem_data  = '0;
    bus.lk_valid  = 1'b0;
    bus.lk_da     = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic write_port(input int idx, input port_addr_t val);
    bus.mem_en    = 1'b1;
    bus.mem_rd_wr = 1'b1;
    bus.mem_add   = port_idx_t'(idx);
    bus.mem_data  = val;
    step();
    bus.mem_en    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    n_cmp++; if (bus.lk_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_lk_out_valid: got %b expected 0", bus.lk_out_valid); end
    n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL reset_lk_port: got %b expected 0000", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b0) begin n_err++; $display("FAIL reset_lk_miss: got %b expected 0", bus.lk_miss); end
    n_cmp++; if (cfg_valid !== 4'b0000) begin n_err++; $display("FAIL reset_cfg_valid: got %b expected 0000", cfg_valid); end
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL reset_dup_err: got %b expected 0", dup_err); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
    apply_reset();
  endtask

  task automatic test_basic_lookup();
    port_addr_t vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    for (int i = 0; i < 4; i++) write_port(i, vals[i]);
    bus.lk_valid = 1'b1;
    bus.lk_da    = 8'h33;
    step();
    bus.lk_valid = 1'b0;
    n_cmp++; if (bus.lk_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b expected 1", bus.lk_out_valid); end
    n_cmp++; if (bus.lk_port !== 4'b0100) begin n_err++; $display("FAIL basic_port: got %b expected 0100", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b0) begin n_err++; $display("FAIL basic_miss: got %b expected 0", bus.lk_miss); end
    n_cmp++; if (cfg_valid !== 4'b1111) begin n_err++; $display("FAIL basic_cfg_valid: got %b expected 1111", cfg_valid); end
    step();
    n_cmp++; if (bus.lk_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_pulse: got %b expected 0", bus.lk_out_valid); end
    n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL basic_port_idle: got %b expected 0000", bus.lk_port); end
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL basic_no_dup: got %b expected 0", dup_err); end
  endtask

  task automatic test_unconfigured();
    apply_reset();
    write_port(1, 8'h22);
    bus.lk_valid = 1'b1;
    bus.lk_da    = 8'h00;
    step();
    n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL unconf_port: got %b expected 0000", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b1) begin n_err++; $display("FAIL unconf_miss: got %b expected 1", bus.lk_miss); end
    bus.lk_da = 8'h22;
    step();
    bus.lk_valid = 1'b0;
    n_cmp++; if (bus.lk_port !== 4'b0010) begin n_err++; $display("FAIL unconf_hit_port: got %b expected 0010", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b0) begin n_err++; $display("FAIL unconf_hit_miss: got %b expected 0", bus.lk_miss); end
    n_cmp++; if (cfg_valid !== 4'b0010) begin n_err++; $display("FAIL unconf_cfg_valid: got %b expected 0010", cfg_valid); end
  endtask

  task automatic test_same_edge();
    apply_reset();
    // Write port 2 and look up its new value at the same edge.
    bus.mem_en    = 1'b1;
    bus.mem_rd_wr = 1'b1;
    bus.mem_add   = 2'd2;
    bus.mem_data  = 8'h55;
    bus.lk_valid  = 1'b1;
    bus.lk_da     = 8'h55;
    step();
    bus.mem_en = 1'b0;
    n_cmp++; if (bus.lk_miss !== 1'b1) begin n_err++; $display("FAIL same_edge_miss: got %b expected 1", bus.lk_miss); end
    n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL same_edge_port: got %b expected 0000", bus.lk_port); end
    step();
    bus.lk_valid = 1'b0;
    n_cmp++; if (bus.lk_port !== 4'b0100) begin n_err++; $display("FAIL next_edge_port: got %b expected 0100", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b0) begin n_err++; $display("FAIL next_edge_miss: got %b expected 0", bus.lk_miss); end
  endtask

  task automatic test_duplicate();
    apply_reset();
    write_port(0, 8'h7A);
    write_port(3, 8'h7A);
    // Duplicate is visible now but not yet registered.
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL dup_early: got %b expected 0", dup_err); end
    bus.lk_valid = 1'b1;
    bus.lk_da    = 8'h7A;
    step();
    bus.lk_valid = 1'b0;
    n_cmp++; if (bus.lk_port !== 4'b0001) begin n_err++; $display("FAIL dup_lowest_port: got %b expected 0001", bus.lk_port); end
    n_cmp++; if (dup_err !== 1'b1) begin n_err++; $display("FAIL dup_set: got %b expected 1", dup_err); end
    // Removing the duplicate must not clear the sticky flag.
    write_port(3, 8'h01);
    repeat (3) step();
    n_cmp++; if (dup_err !== 1'b1) begin n_err++; $display("FAIL dup_sticky: got %b expected 1", dup_err); end
  endtask

  task automatic test_readback();
    apply_reset();
    write_port(1, 8'hC3);
    bus.mem_en    = 1'b1;
    bus.mem_rd_wr = 1'b0;
    bus.mem_add   = 2'd1;
    step();
    bus.mem_en = 1'b0;
    n_cmp++; if (bus.rd_valid !== READBACK) begin n_err++; $display("FAIL rd_valid_pulse: got %b expected %b", bus.rd_valid, READBACK); end
    n_cmp++; if (bus.rd_data !== (READBACK ? 8'hC3 : 8'h00)) begin n_err++; $display("FAIL rd_data: got %h expected %h", bus.rd_data, (READBACK ? 8'hC3 : 8'h00)); end
    step();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_end: got %b expected 0", bus.rd_valid); end
    n_cmp++; if (cfg_valid !== 4'b0010) begin n_err++; $display("FAIL rd_no_state_change: got %b expected 0010", cfg_valid); end
  endtask

  task automatic test_back_to_back_reset();
    port_addr_t da  [4] = '{8'h10, 8'h20, 8'h30, 8'h10};
    port_sel_t  exp [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001};
    logic       mis [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    port_addr_t da2 [3] = '{8'h10, 8'h20, 8'h00};
    apply_reset();
    write_port(0, 8'h10);
    write_port(1, 8'h20);
    write_port(2, 8'h10);
    bus.lk_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.lk_da = da[k];
      step();
      n_cmp++; if (bus.lk_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, bus.lk_out_valid); end
      n_cmp++; if (bus.lk_port !== exp[k]) begin n_err++; $display("FAIL b2b_port[%0d]: got %b expected %b", k, bus.lk_port, exp[k]); end
      n_cmp++; if (bus.lk_miss !== mis[k]) begin n_err++; $display("FAIL b2b_miss[%0d]: got %b expected %b", k, bus.lk_miss, mis[k]); end
    end
    n_cmp++; if (dup_err !== 1'b1) begin n_err++; $display("FAIL b2b_dup_set: got %b expected 1", dup_err); end
    // Assert reset mid-cycle while a hit result is being presented.
    bus.lk_da = 8'h20;
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.lk_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", bus.lk_out_valid); end
    n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL midrst_port: got %b expected 0000", bus.lk_port); end
    n_cmp++; if (bus.lk_miss !== 1'b0) begin n_err++; $display("FAIL midrst_miss: got %b expected 0", bus.lk_miss); end
    n_cmp++; if (cfg_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_cfg_valid: got %b expected 0000", cfg_valid); end
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL midrst_dup: got %b expected 0", dup_err); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rd_valid: got %b expected 0", bus.rd_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.lk_da = da2[k];
      step();
      n_cmp++; if (bus.lk_miss !== 1'b1) begin n_err++; $display("FAIL postrst_miss[%0d]: got %b expected 1", k, bus.lk_miss); end
      n_cmp++; if (bus.lk_port !== 4'b0000) begin n_err++; $display("FAIL postrst_port[%0d]: got %b expected 0000", k, bus.lk_port); end
    end
    bus.lk_valid = 1'b0;
    n_cmp++; if (cfg_valid !== 4'b0000) begin n_err++; $display("FAIL postrst_cfg_valid: got %b expected 0000", cfg_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_lookup();
    test_unconfigured();
    test_same_edge();
    test_duplicate();
    test_readback();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
